// File: rtl/bmult_rr_sched.sv
// Round-robin front end sharing one fixed-latency multiplier among NREQ requesters.
// A tag pipe of LAT stages routes each returning product to its owner.
module bmult_rr_sched #(
  parameter int NREQ = 4,
  parameter int W    = 8,
  parameter int LAT  = 1,
  parameter int IDW  = $clog2(NREQ),
  localparam int IFW = $clog2(LAT+1)+1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_p,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_p,
  output logic [IFW-1:0]    inflight,
  output logic              idle
);

  function automatic logic [NREQ-1:0] onehot(input logic [IDW-1:0] id);
    onehot = {{(NREQ-1){1'b0}}, 1'b1} << id;
  endfunction

  logic [IDW-1:0]  r_ptr;
  logic            r_tag_v  [LAT];
  logic [IDW-1:0]  r_tag_id [LAT];
  logic [NREQ-1:0] r_rsp_valid;
  logic [IDW-1:0]  r_rsp_id;
  logic [2*W-1:0]  r_rsp_p;
  logic [IFW-1:0]  r_inflight;

  logic            w_grant_any;
  logic [IDW-1:0]  w_grant_id;
  logic [IDW-1:0]  w_scan_idx;
  logic            w_hit;
  logic [W-1:0]    w_a_arr [NREQ];
  logic [W-1:0]    w_b_arr [NREQ];
  logic            w_ret;

  // Unpack the operand buses into per-requester slices
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      w_a_arr[i] = req_a[i*W +: W];
      w_b_arr[i] = req_b[i*W +: W];
    end
  end

  // Rotating priority search; scanning from the far end lets the nearest hit win
  always_comb begin
    w_grant_any = 1'b0;
    w_grant_id  = '0;
    w_scan_idx  = '0;
    w_hit       = 1'b0;
    for (int k = NREQ-1; k >= 0; k--) begin
      w_scan_idx  = IDW'((int'(r_ptr) + k) % NREQ);
      w_hit       = en & req_valid[w_scan_idx];
      w_grant_any = w_grant_any | w_hit;
      w_grant_id  = w_hit ? w_scan_idx : w_grant_id;
    end
  end

  // Grant and operand steering toward the shared multiplier
  always_comb begin
    req_ready = '0;
    mul_a     = '0;
    mul_b     = '0;
    if (w_grant_any) begin
      req_ready = onehot(w_grant_id);
      mul_a     = w_a_arr[w_grant_id];
      mul_b     = w_b_arr[w_grant_id];
    end else begin
      req_ready = '0;
    end
  end

  assign w_ret = r_tag_v[LAT-1];

  // Pointer, tag pipe, response register and in-flight counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_rsp_p     <= '0;
      r_inflight  <= '0;
      for (int s = 0; s < LAT; s++) begin
        r_tag_v[s]  <= 1'b0;
        r_tag_id[s] <= '0;
      end
    end else begin
      if (w_grant_any) begin
        r_ptr <= (w_grant_id == IDW'(NREQ-1)) ? '0 : w_grant_id + 1'b1;
      end
      r_tag_v[0]  <= w_grant_any;
      r_tag_id[0] <= w_grant_id;
      for (int s = 1; s < LAT; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
      // The multiplier cannot be stalled, so a returning product is always accepted
      if (w_ret) begin
        r_rsp_valid <= onehot(r_tag_id[LAT-1]);
        r_rsp_id    <= r_tag_id[LAT-1];
        r_rsp_p     <= mul_p;
      end else begin
        r_rsp_valid <= '0;
      end
      case ({w_grant_any, w_ret})
        2'b10:   r_inflight <= r_inflight + IFW'(1);
        2'b01:   r_inflight <= r_inflight - IFW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_p     = r_rsp_p;
  assign inflight  = r_inflight;
  assign idle      = (r_inflight == '0) && (req_valid == '0);

endmodule
